// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared encodings for the multicycle RV32I control path
// (FSM state, opcodes and datapath mux/ALU select values).
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_TRAP     = 4'd10
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10
  } imm_src_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10
  } alu_src_a_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } alu_src_b_e;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_MEMDATA   = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  // States that own the unified memory and run the wait counter.
  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: maps funct3/funct7b5 to an ALU operation for R-type and I-type
// ALU instructions; flags funct3 values with no supported operation.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_rtype,
  output logic [2:0] alu_control,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (funct3)
      // funct7b5 only selects sub for register-register ops; addi ignores IR[30].
      3'b000:  alu_control = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_control = ALU_SLT;
      3'b110:  alu_control = ALU_OR;
      3'b111:  alu_control = ALU_AND;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM of the multicycle RV32I core.
// Define CTRL_ILLEGAL_TRAP_EN to send unsupported opcodes/funct3 to a sticky TRAP state.
//
// state    | meaning
// FETCH    | read instruction at PC, PC+4 -> PC on mem_ready
// DECODE   | branch target -> ALUOut, dispatch on opcode
// MEMADR   | rs1 + imm address for lw/sw
// MEMREAD  | load access at ALUOut
// MEMWB    | load data -> rd
// MEMWRITE | store access at ALUOut
// EXECR    | rs1 op rs2
// EXECI    | rs1 op imm
// ALUWB    | ALUOut -> rd
// BEQ      | compare rs1/rs2, take branch on zero
// TRAP     | illegal instruction, hold until reset
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] imm_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] alu_control,
  output logic       mem_timeout,
  output logic       illegal_instr
);

  localparam logic [7:0] WaitMax = 8'(MEM_WAIT_MAX);
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [2:0] dec_alu;
  logic       funct_illegal;
  logic       timeout;

  alu_decoder u_alu_decoder (
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .is_rtype    (state_q == S_EXECR),
    .alu_control (dec_alu),
    .illegal     (funct_illegal)
  );

  always_comb begin
    state_d       = state_q;
    timeout       = 1'b0;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    imm_src       = IMM_I;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    result_src    = RES_ALUOUT;
    alu_control   = ALU_ADD;
    illegal_instr = 1'b0;

    // Outputs are gated by reset itself so an access drops the instant reset rises.
    if (!reset) begin
      timeout = is_mem_state(state_q) && !mem_ready && (wait_q == WaitMax);
      case (state_q)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALURESULT;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          imm_src   = IMM_B;
          case (opcode)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_RTYPE:          state_d = S_EXECR;
            OP_ITYPE:          state_d = S_EXECI;
            OP_BRANCH:         state_d = S_BEQ;
`ifdef CTRL_ILLEGAL_TRAP_EN
            default:           state_d = S_TRAP;
`else
            default:           state_d = S_FETCH;
`endif
          endcase
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          if (opcode == OP_STORE) begin
            imm_src = IMM_S;
            state_d = S_MEMWRITE;
          end else begin
            imm_src = IMM_I;
            state_d = S_MEMREAD;
          end
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
          if (mem_ready)    state_d = S_MEMWB;
          else if (timeout) state_d = S_FETCH;
        end
        S_MEMWB: begin
          result_src = RES_MEMDATA;
          reg_write  = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
          if (mem_ready || timeout) state_d = S_FETCH;
        end
        S_EXECR: begin
          alu_src_a   = SRCA_RS1;
          alu_src_b   = SRCB_RS2;
          alu_control = dec_alu;
          state_d     = (TrapEn && funct_illegal) ? S_TRAP : S_ALUWB;
        end
        S_EXECI: begin
          alu_src_a   = SRCA_RS1;
          alu_src_b   = SRCB_IMM;
          imm_src     = IMM_I;
          alu_control = dec_alu;
          state_d     = (TrapEn && funct_illegal) ? S_TRAP : S_ALUWB;
        end
        S_ALUWB: begin
          result_src = RES_ALUOUT;
          reg_write  = 1'b1;
          state_d    = S_FETCH;
        end
        S_BEQ: begin
          alu_src_a   = SRCA_RS1;
          alu_src_b   = SRCB_RS2;
          alu_control = ALU_SUB;
          result_src  = RES_ALUOUT;
          pc_write    = zero;
          state_d     = S_FETCH;
        end
        S_TRAP: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          illegal_instr = 1'b1;
`endif
        end
        default: state_d = S_FETCH;
      endcase
    end

    // A timeout out of FETCH lands back in FETCH, so it must clear the count too.
    if ((state_d != state_q) || timeout) begin
      wait_d = '0;
    end else if (is_mem_state(state_q) && !mem_ready) begin
      wait_d = wait_q + 8'd1;
    end else begin
      wait_d = wait_q;
    end

    mem_timeout = timeout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized instruction streams checked cycle by cycle
// against a phase-list model of the control sequence.
`timescale 1ns/1ps
module tb_multicycle_controller;

  localparam int unsigned WAIT_MAX = 3;

  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;

  typedef enum int {
    P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
    P_EXECR, P_EXECI, P_ALUWB, P_BEQ, P_TRAP
  } phase_e;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ir = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]  imm_src, alu_src_a, alu_src_b, result_src;
  logic [2:0]  alu_control;
  logic        mem_timeout, illegal_instr;
  logic [18:0] obs;

  int checks = 0;
  int errors = 0;

  multicycle_controller #(.MEM_WAIT_MAX(WAIT_MAX)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (ir[6:0]),
    .funct3        (ir[14:12]),
    .funct7b5      (ir[30]),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .adr_src       (adr_src),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .reg_write     (reg_write),
    .imm_src       (imm_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .result_src    (result_src),
    .alu_control   (alu_control),
    .mem_timeout   (mem_timeout),
    .illegal_instr (illegal_instr)
  );

  always #5 clk = ~clk;

  assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                imm_src, alu_src_a, alu_src_b, result_src, alu_control,
                mem_timeout, illegal_instr};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] ref_alu(input logic [2:0] f3, input logic f7, input bit rtype);
    case (f3)
      3'b000:  return (rtype && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic phase_e exec_tail(input logic [2:0] f3);
`ifdef CTRL_ILLEGAL_TRAP_EN
    if (!(f3 inside {3'b000, 3'b010, 3'b110, 3'b111})) return P_TRAP;
`endif
    return P_ALUWB;
  endfunction

  // Expected outputs for one cycle of a phase, straight from the per-step control table.
  function automatic logic [18:0] ref_out(input phase_e ph, input logic [31:0] i,
                                          input bit rdy, input bit z, input bit tmo);
    logic       mreq, mwr, adr, irw, pcw, rw, mt, ill;
    logic [1:0] imm, a, b, rs;
    logic [2:0] alu;
    {mreq, mwr, adr, irw, pcw, rw, mt, ill} = '0;
    {imm, a, b, rs} = '0;
    alu = 3'b000;
    case (ph)
      P_FETCH:    begin mreq = 1; b = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; mt = tmo; end
      P_DECODE:   begin a = 2'b01; b = 2'b01; imm = 2'b10; end
      P_MEMADR:   begin a = 2'b10; b = 2'b01; imm = (i[6:0] == OPC_SW) ? 2'b01 : 2'b00; end
      P_MEMREAD:  begin mreq = 1; adr = 1; mt = tmo; end
      P_MEMWB:    begin rs = 2'b01; rw = 1; end
      P_MEMWRITE: begin mreq = 1; mwr = 1; adr = 1; mt = tmo; end
      P_EXECR:    begin a = 2'b10; b = 2'b00; alu = ref_alu(i[14:12], i[30], 1'b1); end
      P_EXECI:    begin a = 2'b10; b = 2'b01; alu = ref_alu(i[14:12], i[30], 1'b0); end
      P_ALUWB:    begin rw = 1; end
      P_BEQ:      begin a = 2'b10; b = 2'b00; alu = 3'b001; pcw = z; end
      P_TRAP:     begin ill = 1; end
      default:    ;
    endcase
    return {mreq, mwr, adr, irw, pcw, rw, imm, a, b, rs, alu, mt, ill};
  endfunction

  // lat_*: cycle on which mem_ready rises (0 = random); beyond WAIT_MAX+1 means never.
  task automatic run_instr(input logic [31:0] instr, input int lat_fetch, input int lat_data,
                           input int zero_fix, input bit rst_in_write,
                           output int n_cyc, output int n_rw, output int n_mw,
                           output int n_ill, output bit tmo_seen, output bit trapped);
    phase_e ph_q[$];
    phase_e ph;
    bit     is_acc, tmo;
    int     lat, ncy;
    n_cyc = 0; n_rw = 0; n_mw = 0; n_ill = 0; tmo_seen = 0; trapped = 0;
    ph_q = {P_FETCH, P_DECODE};
    case (instr[6:0])
      OPC_LW:  begin ph_q.push_back(P_MEMADR); ph_q.push_back(P_MEMREAD); ph_q.push_back(P_MEMWB); end
      OPC_SW:  begin ph_q.push_back(P_MEMADR); ph_q.push_back(P_MEMWRITE); end
      OPC_R:   begin ph_q.push_back(P_EXECR); ph_q.push_back(exec_tail(instr[14:12])); end
      OPC_I:   begin ph_q.push_back(P_EXECI); ph_q.push_back(exec_tail(instr[14:12])); end
      OPC_BEQ: ph_q.push_back(P_BEQ);
      default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        ph_q.push_back(P_TRAP);
`endif
      end
    endcase
    while (ph_q.size() > 0) begin
      ph = ph_q.pop_front();
      is_acc = ph inside {P_FETCH, P_MEMREAD, P_MEMWRITE};
      lat = (ph == P_FETCH) ? lat_fetch : lat_data;
      if (lat <= 0) lat = int'($urandom_range(1, WAIT_MAX + 2));
      if (is_acc) ncy = (lat > int'(WAIT_MAX) + 1) ? int'(WAIT_MAX) + 1 : lat;
      else        ncy = (ph == P_TRAP) ? 3 : 1;
      tmo = 1'b0;
      for (int k = 1; k <= ncy; k++) begin
        @(negedge clk);
        ir = instr;
        mem_ready = is_acc ? (k == lat) : 1'($urandom_range(0, 1));
        zero = (ph == P_BEQ && zero_fix >= 0) ? zero_fix[0] : 1'($urandom_range(0, 1));
        tmo = is_acc && (k == int'(WAIT_MAX) + 1) && !mem_ready;
        #1;
        check_val($sformatf("%s cyc%0d", ph.name(), k), 32'(obs),
                  32'(ref_out(ph, instr, mem_ready, zero, tmo)));
        n_cyc++;
        if (reg_write) n_rw++;
        if (mem_write) n_mw++;
        if (illegal_instr) n_ill++;
        if (mem_timeout) tmo_seen = 1'b1;
        if (rst_in_write && ph == P_MEMWRITE) begin
          #2 reset = 1'b1;
          #1;
          check_val("rst mid-write mem_req", 32'(mem_req), 32'd0);
          check_val("rst mid-write mem_write", 32'(mem_write), 32'd0);
          @(posedge clk);
          #1 reset = 1'b0;
          return;
        end
      end
      if (tmo) ph_q.delete();
      if (ph == P_TRAP) trapped = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    check_val("outputs in reset", 32'(obs), 32'd0);
    mem_ready = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int nc, nr, nm, ni;
    bit to, tr;
    logic [31:0] r;
    logic [6:0]  bad_ops [6];
    bad_ops = '{7'h7F, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h00};

    do_reset();

    run_instr(32'h00402083, 2, 2, -1, 0, nc, nr, nm, ni, to, tr);
    check_val("lw total cycles", 32'(nc), 32'd7);
    check_val("lw reg_write cycles", 32'(nr), 32'd1);

    run_instr(32'h00112223, 2, 2, -1, 0, nc, nr, nm, ni, to, tr);
    check_val("sw reg_write cycles", 32'(nr), 32'd0);
    check_val("sw mem_write cycles", 32'(nm), 32'd2);

    run_instr(32'h40208033, 0, 0, -1, 0, nc, nr, nm, ni, to, tr);
    run_instr(32'h0020F033, 0, 0, -1, 0, nc, nr, nm, ni, to, tr);
    run_instr(32'h40000093, 0, 0, -1, 0, nc, nr, nm, ni, to, tr);

    run_instr(32'h00208063, 2, 2, 1, 0, nc, nr, nm, ni, to, tr);
    run_instr(32'h00208063, 2, 2, 0, 0, nc, nr, nm, ni, to, tr);

    run_instr(32'h00402083, 2, WAIT_MAX + 2, -1, 0, nc, nr, nm, ni, to, tr);
    check_val("lw timeout pulse", 32'(to), 32'd1);
    check_val("lw timeout reg_write", 32'(nr), 32'd0);
    check_val("lw timeout cycles", 32'(nc), 32'(4 + WAIT_MAX + 1));

    run_instr(32'h00402083, 2, WAIT_MAX + 1, -1, 0, nc, nr, nm, ni, to, tr);
    check_val("lw late ready pulse", 32'(to), 32'd0);
    check_val("lw late ready reg_write", 32'(nr), 32'd1);

    run_instr(32'h00402083, WAIT_MAX + 2, 2, -1, 0, nc, nr, nm, ni, to, tr);
    check_val("fetch timeout pulse", 32'(to), 32'd1);
    check_val("fetch timeout cycles", 32'(nc), 32'(WAIT_MAX + 1));

    run_instr(32'h0000007F, 2, 2, -1, 0, nc, nr, nm, ni, to, tr);
`ifdef CTRL_ILLEGAL_TRAP_EN
    check_val("illegal opcode trap cycles", 32'(ni), 32'd3);
`else
    check_val("illegal opcode nop cycles", 32'(nc), 32'd3);
`endif
    if (tr) do_reset();

    run_instr(32'h00112223, 2, 2, -1, 1, nc, nr, nm, ni, to, tr);
    run_instr(32'h00402083, 2, 2, -1, 0, nc, nr, nm, ni, to, tr);

    for (int n = 0; n < 150; n++) begin
      r = $urandom();
      case ($urandom_range(0, 5))
        0: r[6:0] = OPC_LW;
        1: r[6:0] = OPC_SW;
        2: begin r[6:0] = OPC_R; r[31] = 1'b0; r[29:25] = 5'd0; end
        3: r[6:0] = OPC_I;
        4: r[6:0] = OPC_BEQ;
        default: r[6:0] = bad_ops[$urandom_range(0, 5)];
      endcase
      run_instr(r, 0, 0, -1, 0, nc, nr, nm, ni, to, tr);
      if (tr) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
